// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD scan controller.
//   DIGITS      number of display digits / BCD nibbles
//   MAX_VAL     largest value the 4-digit display can show; larger inputs saturate
//   SEL_*       active-low one-hot digit select codes
//   state_e     handshake FSM states
//   sel_for_idx maps a scan index (0 = ones .. 3 = thousands) to its select code
package bcd_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam logic [13:0] MAX_VAL = 14'd9999;

    localparam logic [3:0] SEL_ONES = 4'b1110;
    localparam logic [3:0] SEL_TENS = 4'b1101;
    localparam logic [3:0] SEL_HUND = 4'b1011;
    localparam logic [3:0] SEL_THOU = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_e;

    function automatic logic [3:0] sel_for_idx(input logic [1:0] idx);
        logic [3:0] sel;
        unique case (idx)
            2'd0: sel = SEL_ONES;
            2'd1: sel = SEL_TENS;
            2'd2: sel = SEL_HUND;
            2'd3: sel = SEL_THOU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  load bin and begin a conversion (ignored state is overwritten)
//   bin    binary operand, sampled when start is high
//   busy   shifts still pending
//   done   high in the cycle whose closing edge performs the final shift
//   bcd    packed BCD result, ones in [3:0]; valid once busy drops
module bin2bcd_dd
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt_q;

    // Add-3 correction so each nibble carries correctly after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(BIN_W);
        end else if (busy) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q          <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Accepts a binary value over valid/ready, converts it to four BCD digits and
// time-multiplexes them onto a 4-digit display.
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_bin      binary value to display (values above 9999 saturate)
//   i_valid    i_bin valid; held stable until accepted
//   o_ready    idle and able to accept
//   o_done     1-cycle pulse after new digits are committed
//   o_ovf      last accepted value was saturated
//   o_sel_bcd  active-low one-hot digit select
//   o_digit    {4'h0, BCD digit} for the selected position
module bcd_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BIN_W    = 14
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [BIN_W-1:0] i_bin,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_ovf,
    output logic [3:0]       o_sel_bcd,
    output logic [7:0]       o_digit
);

    localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_VAL);
    localparam int unsigned      SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_e              state_q, state_d;
    logic                xfer;
    logic [BIN_W-1:0]    sat_bin;
    logic                dd_busy, dd_done;
    logic [4*DIGITS-1:0] dd_bcd;

    logic                done_q, ovf_q;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          sel_q, sel_d;
    logic [7:0]          digit_q, digit_d;

    assign o_ready = (state_q == IDLE);
    assign xfer    = i_valid & o_ready;
    assign sat_bin = (i_bin > MAX_BIN) ? MAX_BIN : i_bin;

    bin2bcd_dd #(
        .BIN_W (BIN_W)
    ) u_dd (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (xfer),
        .bin   (sat_bin),
        .busy  (dd_busy),
        .done  (dd_done),
        .bcd   (dd_bcd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (xfer) state_d = CONV;
            CONV: begin
                if (dd_done) begin
                    state_d = LOAD;
                end else if (!dd_busy) begin
                    // Datapath idle without finishing: recover rather than hang.
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == LOAD);
            if (xfer) begin
                ovf_q <= (i_bin > MAX_BIN);
            end
        end
    end

    // Scan and display. Select and digit are registered from next-state values so
    // they move together, and a commit shows up on the very edge it happens.
    always_comb begin
        disp_d     = (state_q == LOAD) ? dd_bcd : disp_q;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        sel_d   = sel_for_idx(idx_d);
        digit_d = {4'h0, disp_d[{idx_d, 2'b00} +: 4]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_q     <= '0;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            sel_q      <= SEL_ONES;
            digit_q    <= 8'h00;
        end else begin
            disp_q     <= disp_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            digit_q    <= digit_d;
        end
    end

    assign o_done    = done_q;
    assign o_ovf     = ovf_q;
    assign o_sel_bcd = sel_q;
    assign o_digit   = digit_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
module tb_bcd_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [13:0] bin;
    logic        valid;
    logic        ready;
    logic        done;
    logic        ovf;
    logic [3:0]  sel;
    logic [7:0]  digit;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_scan_ctrl #(
        .SCAN_DIV (3),
        .BIN_W    (14)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_bin     (bin),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_done    (done),
        .o_ovf     (ovf),
        .o_sel_bcd (sel),
        .o_digit   (digit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present v at a negedge once ready; returns one cycle after the transfer edge.
    task automatic send(input logic [13:0] v);
        int i = 0;
        while (!ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        bin   = v;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!done && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {15'd0, done}, 16'd1);
    endtask

    // With SCAN_DIV=3, four samples 3 cycles apart visit every position once.
    task automatic check_display(input string tag, input logic [15:0] exp);
        for (int k = 0; k < 4; k++) begin
            case (sel)
                4'b1110: chk({tag, " ones"}, {8'd0, digit}, {12'd0, exp[3:0]});
                4'b1101: chk({tag, " tens"}, {8'd0, digit}, {12'd0, exp[7:4]});
                4'b1011: chk({tag, " hund"}, {8'd0, digit}, {12'd0, exp[11:8]});
                4'b0111: chk({tag, " thou"}, {8'd0, digit}, {12'd0, exp[15:12]});
                default: chk({tag, " sel"}, {12'd0, sel}, 16'h000e);
            endcase
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);

        // 1: reset values, then scan stepping every 3 cycles
        chk("rst ready", {15'd0, ready}, 16'd1);
        chk("rst done",  {15'd0, done},  16'd0);
        chk("rst ovf",   {15'd0, ovf},   16'd0);
        chk("rst sel",   {12'd0, sel},   16'h000e);
        chk("rst digit", {8'd0, digit},  16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("scan hold", {12'd0, sel}, 16'h000e);
        @(negedge clk);
        chk("scan idx1", {12'd0, sel}, 16'h000d);
        repeat (3) @(negedge clk);
        chk("scan idx2", {12'd0, sel}, 16'h000b);
        repeat (3) @(negedge clk);
        chk("scan idx3", {12'd0, sel}, 16'h0007);
        repeat (3) @(negedge clk);
        chk("scan wrap", {12'd0, sel}, 16'h000e);

        // 2: 1234, latency and digit/select pairing
        send(14'd1234);
        chk("lat ready k0", {15'd0, ready}, 16'd0);
        repeat (14) @(negedge clk);
        chk("lat done k14",  {15'd0, done},  16'd0);
        chk("lat ready k14", {15'd0, ready}, 16'd0);
        @(negedge clk);
        chk("lat done k15",  {15'd0, done},  16'd1);
        chk("lat ready k15", {15'd0, ready}, 16'd1);
        @(negedge clk);
        chk("lat done k16",  {15'd0, done},  16'd0);
        check_display("d1234", 16'h1234);
        chk("ovf 1234", {15'd0, ovf}, 16'd0);

        // 3: saturation and ovf clearing
        send(14'd12000);
        chk("ovf on xfer", {15'd0, ovf}, 16'd1);
        wait_done("done 12000");
        check_display("d12000", 16'h9999);
        chk("ovf sticky", {15'd0, ovf}, 16'd1);
        send(14'd5);
        chk("ovf clr", {15'd0, ovf}, 16'd0);
        wait_done("done 5");
        check_display("d5", 16'h0005);

        // 4: valid held during busy is not captured until ready returns
        send(14'd7777);
        bin   = 14'd42;
        valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy ready k5", {15'd0, ready}, 16'd0);
        repeat (9) @(negedge clk);
        chk("busy ready k14", {15'd0, ready}, 16'd0);
        @(negedge clk);
        chk("busy done 7777", {15'd0, done},  16'd1);
        chk("busy ready k15", {15'd0, ready}, 16'd1);
        @(negedge clk);
        valid = 1'b0;
        chk("42 captured", {15'd0, ready}, 16'd0);
        check_display("d7777", 16'h7777);
        wait_done("done 42");
        check_display("d42", 16'h0042);

        // 5: reset in the middle of a conversion
        send(14'd12000);
        wait_done("done pre-rst");
        chk("ovf pre-rst", {15'd0, ovf}, 16'd1);
        send(14'd8888);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst ready", {15'd0, ready}, 16'd1);
        chk("mid rst done",  {15'd0, done},  16'd0);
        chk("mid rst ovf",   {15'd0, ovf},   16'd0);
        chk("mid rst sel",   {12'd0, sel},   16'h000e);
        chk("mid rst digit", {8'd0, digit},  16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_display("d after rst", 16'h0000);
        send(14'd7);
        wait_done("done 7");
        check_display("d7", 16'h0007);

        // 6: boundaries 0 and 9999
        send(14'd12000);
        wait_done("done sat");
        send(14'd0);
        wait_done("done 0");
        chk("ovf 0", {15'd0, ovf}, 16'd0);
        check_display("d0", 16'h0000);
        send(14'd9999);
        wait_done("done 9999");
        chk("ovf 9999", {15'd0, ovf}, 16'd0);
        check_display("d9999", 16'h9999);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
